sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 4, max accepted-but-unanswered transactions (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while inst waits.
REQ-003 SHALL have ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
inst_req  in  1  instruction port request.
inst_addr  in  32  instruction fetch address (reads only; size fixed 2'b10).
inst_addr_ok  out  1  instruction request accepted this cycle.
inst_data_ok  out  1  instruction read data valid this cycle.
inst_rdata  out  32  instruction read data.
data_req  in  1  data port request.
data_wr  in  1  1=write, 0=read.
data_size  in  2  0=byte, 1=half, 2=word.
data_addr  in  32  data address.
data_wdata  in  32  write data.
data_addr_ok  out  1  data request accepted this cycle.
data_data_ok  out  1  data read returned or write completed this cycle.
data_rdata  out  32  data read data.
mem_req  out  1  downstream request.
mem_wr  out  1  downstream write flag.
mem_size  out  2  downstream size.
mem_addr  out  32  downstream address.
mem_wdata  out  32  downstream write data.
mem_addr_ok  in  1  downstream accepted request.
mem_data_ok  in  1  downstream response, in acceptance order.
mem_rdata  in  32  downstream read data.

Function
REQ-004 SHALL select a winner combinationally each cycle: data over inst, except when starvation override is active (REQ-008), then inst over data.
REQ-005 SHALL drive mem_req = (inst_req | data_req) & !fifo_full; mem_wr/size/addr/wdata from winner (inst: wr=0, size=2, wdata=0).
REQ-006 SHALL assert winner's addr_ok = mem_req & mem_addr_ok; loser's addr_ok SHALL be 0; both 0 when fifo_full.
REQ-007 SHALL push winner owner id into an OUTSTANDING-deep owner FIFO on mem_req & mem_addr_ok; pop on mem_data_ok.
REQ-008 SHALL count consecutive data grants while inst_req high; at STARVE_LIMIT, override active until next inst grant, which clears counter; counter clears whenever inst_req low.
REQ-009 SHALL route mem_data_ok to inst_data_ok or data_data_ok per FIFO head, same cycle (zero latency); mem_rdata fans out to both rdata outputs unchanged.
REQ-010 SHALL handle simultaneous push and pop: count unchanged, head advances, new entry written.
REQ-011 SHALL treat full as count==OUTSTANDING; a pop in a full cycle does not enable a push that cycle (no full-bypass).
REQ-012 SHALL ignore mem_data_ok when FIFO empty (no data_ok asserted, count stays 0); simulation assertion flags it.
REQ-013 SHALL wrap FIFO read/write pointers modulo OUTSTANDING.
REQ-014 SHALL NOT cancel accepted transactions; upstream flush-discard is upstream responsibility.

Reset
REQ-015 SHALL on reset: FIFO empty, pointers 0, count 0, starvation counter 0, override 0.
REQ-016 SHALL drive all addr_ok/data_ok/mem_req low during reset regardless of inputs; reset mid-transaction discards outstanding ownership, later mem_data_ok ignored per REQ-012.

Structure
REQ-017 SHALL place mem_owner_t (OWNER_INST=0, OWNER_DATA=1) in cpu_defs.svh.
REQ-018 SHALL implement owner FIFO as sub-module owner_fifo (parameterised depth/width, push/pop/full/empty/head).

Verification
REQ-019 Both req high, mem_addr_ok=1, idle -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr.
REQ-020 inst read 0xBFC00000 accepted, then data read accepted; two mem_data_ok with 0x11111111, 0x22222222 -> inst_data_ok with 0x11111111, then data_data_ok with 0x22222222.
REQ-021 4 accepts, no responses -> mem_req=0, both addr_ok=0; one mem_data_ok -> mem_req re-asserts next cycle.
REQ-022 Both req held high, mem_addr_ok=1, responses returned -> 4 data grants then 1 inst grant, repeating.
REQ-023 Full FIFO, mem_data_ok and requests same cycle -> pop only, count 4->3, no addr_ok.
REQ-024 Reset asserted with 2 outstanding -> count 0; subsequent mem_data_ok produces no data_ok.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared types and constants for the SRAM arbiter slice.
//   mem_owner_t : which upstream port owns an accepted downstream transaction.
//   SIZE_WORD   : transfer size code used for instruction fetches.
package sram_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } mem_owner_t;

    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_arbiter_owner_fifo.sv
// owner_fifo: small circular FIFO recording the owner of each accepted transaction.
// Ports:
//   clk, reset         clock; synchronous active-high reset (empties the FIFO)
//   push, push_data    write an entry (ignored while full)
//   pop                drop the head entry (ignored while empty)
//   head               entry at the head of the FIFO
//   full, empty        occupancy flags; full means count == DEPTH
module owner_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap keeps the pointers correct even if DEPTH were not a power of 2.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Push qualified by the pre-pop full flag: a pop in a full cycle frees no slot yet.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: merges an instruction-fetch port and a data port onto one
// pipelined SRAM-style bus with up to OUTSTANDING accepted-but-unanswered
// transactions. Responses return in acceptance order and are steered back to
// the owning port through an owner FIFO.
// Ports:
//   clk, reset                         clock; synchronous active-high reset
//   inst_req/addr -> inst_addr_ok      instruction request channel (word reads)
//   inst_data_ok, inst_rdata           instruction response channel
//   data_req/wr/size/addr/wdata        data request channel
//   data_addr_ok                       data request accepted
//   data_data_ok, data_rdata           data response channel
//   mem_req/wr/size/addr/wdata         downstream request channel
//   mem_addr_ok                        downstream accepted request
//   mem_data_ok, mem_rdata             downstream response, in acceptance order
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING  = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    mem_owner_t winner;
    mem_owner_t head_owner;
    logic [0:0] head_bits;
    logic       fifo_full, fifo_empty;
    logic       accept, resp_valid;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             override_q, override_d;

    // Data normally wins; the override flips priority only while inst is asking.
    always_comb begin
        winner = OWNER_INST;
        if (data_req && !(override_q && inst_req)) begin
            winner = OWNER_DATA;
        end
    end

    always_comb begin
        mem_req   = (inst_req | data_req) & ~fifo_full & ~reset;
        mem_wr    = 1'b0;
        mem_size  = SIZE_WORD;
        mem_addr  = inst_addr;
        mem_wdata = '0;
        if (winner == OWNER_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (winner == OWNER_INST);
    assign data_addr_ok = accept & (winner == OWNER_DATA);

    // Responses with nothing outstanding are dropped rather than misrouted.
    assign head_owner   = mem_owner_t'(head_bits);
    assign resp_valid   = mem_data_ok & ~fifo_empty & ~reset;
    assign inst_data_ok = resp_valid & (head_owner == OWNER_INST);
    assign data_data_ok = resp_valid & (head_owner == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    owner_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (winner),
        .pop       (resp_valid),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Starvation tracking: counts data grants while inst waits. Inst no longer
    // waiting (request dropped) or being granted ends the episode.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        override_d   = override_q;
        if (!inst_req) begin
            starve_cnt_d = '0;
            override_d   = 1'b0;
        end else if (accept) begin
            if (winner == OWNER_DATA) begin
                if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
                if (starve_cnt_q >= CNT_W'(STARVE_LIMIT - 1)) begin
                    override_d = 1'b1;
                end
            end else begin
                starve_cnt_d = '0;
                override_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            override_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            override_q   <= override_d;
        end
    end

    spurious_data_ok: assert property (@(posedge clk) disable iff (reset)
        !(mem_data_ok && fifo_empty))
        else $warning("mem_data_ok with no outstanding transaction ignored");

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a transaction-level model (owner queue + starvation streak).
module tb_sram_arbiter;

    localparam int OUTSTANDING  = 4;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(
        .OUTSTANDING  (OUTSTANDING),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: owners of outstanding transactions (1 = data port),
    // data grants in a row while inst waits, and inst-first priority flag.
    bit owner_q[$];
    int streak;
    bit inst_first;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_inputs(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                              input bit dwr, input logic [1:0] dsize,
                              input logic [31:0] daddr, input logic [31:0] dwdata,
                              input bit aok, input bit dok, input logic [31:0] rdata);
        inst_req    = ireq;
        inst_addr   = iaddr;
        data_req    = dreq;
        data_wr     = dwr;
        data_size   = dsize;
        data_addr   = daddr;
        data_wdata  = dwdata;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
    endtask

    // Called at the negedge: compare outputs to the model, then advance the
    // model to the state it holds after the coming posedge.
    task automatic model_cycle();
        bit full, exp_req, dwin, acc, pop, head;
        full    = (owner_q.size() == OUTSTANDING);
        exp_req = !reset && (inst_req || data_req) && !full;
        dwin    = data_req && !(inst_first && inst_req);
        acc     = exp_req && mem_addr_ok;
        pop     = !reset && mem_data_ok && (owner_q.size() > 0);
        head    = (owner_q.size() > 0) ? owner_q[0] : 1'b0;

        check_val("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) begin
            check_val("mem_addr",  mem_addr,  dwin ? data_addr : inst_addr);
            check_val("mem_wr",    32'(mem_wr), dwin ? 32'(data_wr) : 32'd0);
            check_val("mem_size",  32'(mem_size), dwin ? 32'(data_size) : 32'd2);
            check_val("mem_wdata", mem_wdata, dwin ? data_wdata : 32'd0);
        end
        check_val("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && !dwin));
        check_val("data_addr_ok", 32'(data_addr_ok), 32'(acc && dwin));
        check_val("inst_data_ok", 32'(inst_data_ok), 32'(pop && !head));
        check_val("data_data_ok", 32'(data_data_ok), 32'(pop && head));
        if (pop) begin
            check_val(head ? "data_rdata" : "inst_rdata",
                      head ? data_rdata : inst_rdata, mem_rdata);
        end

        if (reset) begin
            owner_q.delete();
            streak     = 0;
            inst_first = 1'b0;
        end else begin
            if (pop) void'(owner_q.pop_front());
            if (acc) owner_q.push_back(dwin);
            if (!inst_req) begin
                streak     = 0;
                inst_first = 1'b0;
            end else if (acc) begin
                if (dwin) begin
                    streak++;
                    if (streak >= STARVE_LIMIT) inst_first = 1'b1;
                end else begin
                    streak     = 0;
                    inst_first = 1'b0;
                end
            end
        end
    endtask

    task automatic finish_cycle();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_inputs(1, 32'h1000_0000, 1, 1, 2'd2, 32'h2000_0000, 32'hDEAD_BEEF, 1, 1, 32'h0);
        @(posedge clk);
        #1;
        // Outputs held low in reset despite active inputs.
        @(negedge clk);
        check_val("reset_mem_req", 32'(mem_req), 32'd0);
        check_val("reset_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        check_val("reset_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        finish_cycle();
        reset = 1'b0;

        // Both request while idle: data wins.
        set_inputs(1, 32'hBFC0_0000, 1, 0, 2'd2, 32'h8000_1000, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        check_val("both_req_data_wins", 32'({data_addr_ok, inst_addr_ok}), 32'b10);
        check_val("both_req_mem_addr", mem_addr, 32'h8000_1000);
        finish_cycle();

        // Inst then data accepted; responses routed in order.
        do_reset();
        set_inputs(1, 32'hBFC0_0000, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0);
        cycle();
        set_inputs(0, 32'h0, 1, 0, 2'd2, 32'h8000_2000, 32'h0, 1, 0, 32'h0);
        cycle();
        set_inputs(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h1111_1111);
        @(negedge clk);
        check_val("order_inst_resp", 32'({inst_data_ok, data_data_ok}), 32'b10);
        check_val("order_inst_rdata", inst_rdata, 32'h1111_1111);
        finish_cycle();
        set_inputs(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h2222_2222);
        @(negedge clk);
        check_val("order_data_resp", 32'({inst_data_ok, data_data_ok}), 32'b01);
        check_val("order_data_rdata", data_rdata, 32'h2222_2222);
        finish_cycle();

        // Fill to OUTSTANDING, then full-cycle pop with requests pending.
        do_reset();
        for (int i = 0; i < OUTSTANDING; i++) begin
            set_inputs(1, 32'h100 + 32'(i), 1, 1, 2'd1, 32'h200 + 32'(i), 32'(i), 1, 0, 32'h0);
            cycle();
        end
        @(negedge clk);
        check_val("full_mem_req", 32'(mem_req), 32'd0);
        check_val("full_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        finish_cycle();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFE_0001;
        @(negedge clk);
        check_val("full_pop_mem_req", 32'(mem_req), 32'd0);
        check_val("full_pop_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        check_val("full_pop_data_ok", 32'(data_data_ok), 32'd1);
        finish_cycle();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check_val("after_pop_mem_req", 32'(mem_req), 32'd1);
        check_val("after_pop_inst_grant", 32'(inst_addr_ok), 32'd1);
        finish_cycle();

        // Reset with two outstanding; later response is ignored.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_inputs(i == 0, 32'h300, i == 1, 0, 2'd2, 32'h400, 32'h0, 1, 0, 32'h0);
            cycle();
        end
        set_inputs(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h5555_5555);
        do_reset();
        @(negedge clk);
        check_val("post_reset_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        finish_cycle();
        mem_data_ok = 1'b0;
        // Capacity back to OUTSTANDING confirms the count restarted at 0.
        for (int i = 0; i < OUTSTANDING; i++) begin
            set_inputs(0, 32'h0, 1, 0, 2'd2, 32'h500 + 32'(i), 32'h0, 1, 0, 32'h0);
            @(negedge clk);
            check_val("post_reset_capacity", 32'(data_addr_ok), 32'd1);
            finish_cycle();
        end

        // Starvation: both held high, responses flowing.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_inputs(1, 32'h600 + 32'(i), 1, 0, 2'd2, 32'h700 + 32'(i), 32'h0, 1,
                       owner_q.size() > 0, $urandom);
            @(negedge clk);
            check_val("starve_inst_grant", 32'(inst_addr_ok), 32'(i % 5 == 4));
            check_val("starve_data_grant", 32'(data_addr_ok), 32'(i % 5 != 4));
            finish_cycle();
        end

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            set_inputs($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                       $urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom, $urandom,
                       $urandom_range(0, 3) != 0,
                       (owner_q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
